// File: rtl/writeback_commit_unit_l4_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_commit_unit_l4_if: execute-result, completion and commit bus    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface writeback_commit_unit_l4_if #(
  parameter int p_num_pipes      = 1,
  parameter int p_commit_width   = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  logic [p_num_pipes-1:0]                            ex_val;
  logic [p_num_pipes-1:0]                            ex_rdy;
  logic [p_num_pipes-1:0][31:0]                      ex_pc;
  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]        ex_seq_num;
  logic [p_num_pipes-1:0][4:0]                       ex_waddr;
  logic [p_num_pipes-1:0][31:0]                      ex_wdata;
  logic [p_num_pipes-1:0]                            ex_wen;
  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_preg;
  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_ppreg;

  logic                                              complete_val;
  logic [p_seq_num_bits-1:0]                         complete_seq_num;
  logic [4:0]                                        complete_waddr;
  logic [31:0]                                       complete_wdata;
  logic                                              complete_wen;
  logic [p_phys_addr_bits-1:0]                       complete_preg;

  logic [p_commit_width-1:0]                         commit_val;
  logic [p_commit_width-1:0][p_seq_num_bits-1:0]     commit_seq_num;
  logic [p_commit_width-1:0][31:0]                   commit_pc;
  logic [p_commit_width-1:0][4:0]                    commit_waddr;
  logic [p_commit_width-1:0][31:0]                   commit_wdata;
  logic [p_commit_width-1:0]                         commit_wen;
  logic [p_commit_width-1:0][p_phys_addr_bits-1:0]   commit_ppreg;

  logic                                              squash_val;
  logic [p_seq_num_bits-1:0]                         squash_seq_num;

  modport master (
    output ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen, ex_preg, ex_ppreg,
    output squash_val, squash_seq_num,
    input  ex_rdy,
    input  complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
    input  complete_preg,
    input  commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen,
    input  commit_ppreg
  );

  modport slave (
    input  ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen, ex_preg, ex_ppreg,
    input  squash_val, squash_seq_num,
    output ex_rdy,
    output complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
    output complete_preg,
    output commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen,
    output commit_ppreg
  );
endinterface
`default_nettype wire

// File: rtl/writeback_commit_unit_l4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_commit_unit_l4: RR writeback select, seq-indexed ROB, in-order  |
// | multi-lane commit with squash of younger entries.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module writeback_commit_unit_l4 #(
  parameter int p_num_pipes      = 1,
  parameter int p_commit_width   = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  writeback_commit_unit_l4_if.slave   bus
);
  localparam int DEPTH = 2 ** p_seq_num_bits;
  localparam int PW    = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  typedef logic [p_seq_num_bits-1:0]   seq_t;
  typedef logic [p_phys_addr_bits-1:0] preg_t;

  logic [PW-1:0] prio;
  logic [PW-1:0] gnt_idx;
  logic          fire;
  seq_t          head;
  logic [DEPTH-1:0] rob_valid;
  logic [DEPTH-1:0] valid_nxt;

  logic          x_val;
  seq_t          x_seq;
  logic [31:0]   x_pc;
  logic [4:0]    x_waddr;
  logic [31:0]   x_wdata;
  logic          x_wen;
  preg_t         x_ppreg;

  logic [31:0]   rob_pc    [DEPTH];
  logic [4:0]    rob_waddr [DEPTH];
  logic [31:0]   rob_wdata [DEPTH];
  logic [DEPTH-1:0] rob_wen;
  preg_t         rob_ppreg [DEPTH];

  seq_t          age_s;
  logic          drop_fire;
  logic          ins;
  logic          chain;
  logic [p_commit_width-1:0] commit_ok;
  seq_t          commit_cnt;

  // Scan from lowest offset last so the pipe nearest the priority pointer wins.
  always_comb begin
    fire    = 1'b0;
    gnt_idx = '0;
    for (int i = p_num_pipes - 1; i >= 0; i--) begin
      if (bus.ex_val[(int'(prio) + i) % p_num_pipes]) begin
        fire    = 1'b1;
        gnt_idx = PW'((int'(prio) + i) % p_num_pipes);
      end
    end
  end

  always_comb begin
    bus.ex_rdy = '0;
    if (fire) bus.ex_rdy[gnt_idx] = 1'b1;
  end

  assign bus.complete_val     = fire;
  assign bus.complete_seq_num = bus.ex_seq_num[gnt_idx];
  assign bus.complete_waddr   = bus.ex_waddr[gnt_idx];
  assign bus.complete_wdata   = bus.ex_wdata[gnt_idx];
  assign bus.complete_wen     = fire && bus.ex_wen[gnt_idx] && (bus.ex_waddr[gnt_idx] != 5'd0);
  assign bus.complete_preg    = bus.ex_preg[gnt_idx];

  // Ages are distances from head; anything at or beyond the squash age is discarded.
  assign age_s     = seq_t'(bus.squash_seq_num - head);
  assign drop_fire = bus.squash_val && (seq_t'(bus.complete_seq_num - head) >= age_s);
  assign ins       = x_val && !(bus.squash_val && (seq_t'(x_seq - head) >= age_s));

  always_comb begin
    commit_ok  = '0;
    commit_cnt = '0;
    chain      = 1'b1;
    for (int k = 0; k < p_commit_width; k++) begin
      chain = chain && rob_valid[seq_t'(head + seq_t'(k))]
                    && !(bus.squash_val && (seq_t'(k) >= age_s));
      commit_ok[k] = chain;
      commit_cnt   = commit_cnt + seq_t'(chain);
    end
  end

  assign bus.commit_val = commit_ok;

  for (genvar k = 0; k < p_commit_width; k++) begin : g_lane
    seq_t idx;
    assign idx                    = seq_t'(head + seq_t'(k));
    assign bus.commit_seq_num[k]  = idx;
    assign bus.commit_pc[k]       = rob_pc[idx];
    assign bus.commit_waddr[k]    = rob_waddr[idx];
    assign bus.commit_wdata[k]    = rob_wdata[idx];
    assign bus.commit_wen[k]      = rob_wen[idx];
    assign bus.commit_ppreg[k]    = rob_ppreg[idx];
  end

  always_comb begin
    valid_nxt = rob_valid;
    for (int k = 0; k < p_commit_width; k++) begin
      if (commit_ok[k]) valid_nxt[seq_t'(head + seq_t'(k))] = 1'b0;
    end
    if (bus.squash_val) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (seq_t'(seq_t'(j) - head) >= age_s) valid_nxt[j] = 1'b0;
      end
    end
    if (ins) valid_nxt[x_seq] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= '0;
      head      <= '0;
      rob_valid <= '0;
      x_val     <= 1'b0;
    end else begin
      if (fire) prio <= (gnt_idx == PW'(p_num_pipes - 1)) ? '0 : gnt_idx + 1'b1;
      head      <= head + commit_cnt;
      rob_valid <= valid_nxt;
      x_val     <= fire && !drop_fire;
    end
  end

  // Payload registers carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (fire) begin
      x_seq   <= bus.complete_seq_num;
      x_pc    <= bus.ex_pc[gnt_idx];
      x_waddr <= bus.complete_waddr;
      x_wdata <= bus.complete_wdata;
      x_wen   <= bus.complete_wen;
      x_ppreg <= bus.ex_ppreg[gnt_idx];
    end
    if (ins) begin
      rob_pc[x_seq]    <= x_pc;
      rob_waddr[x_seq] <= x_waddr;
      rob_wdata[x_seq] <= x_wdata;
      rob_wen[x_seq]   <= x_wen;
      rob_ppreg[x_seq] <= x_ppreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ins) begin
      assert (!rob_valid[x_seq]) else $error("insert into occupied ROB slot %0d", x_seq);
    end
  end
endmodule
`default_nettype wire
